// File: rtl/wb_counter_bank.sv
`default_nettype none
// ============================================================================
// Module   : wb_counter_bank
// Purpose  : Bank of NCH independent up/down counter-timers with per-channel
//            limit, periodic/one-shot mode, sticky match flag and interrupt.
//            Programmed through a Wishbone slave port and bulk-loadable from
//            the logic-analyzer probes.
// Ports    : clk, reset        - clock, synchronous active-high reset
//            wbs_*             - Wishbone slave (byte address, 32-bit data)
//                                adr[3:2] = register, adr[4+:CHB] = channel
//            la_load/la_sel/la_value - LA count load strobe, channel, value
//            count_bus         - every channel's count, ch i at [i*WIDTH+:WIDTH]
//            irq               - per-channel interrupt (match & irq_en)
// Register map (per channel):
//            0 CTRL   [0] en, [1] dir (1 = down), [2] oneshot, [3] irq_en
//            1 COUNT  read/write
//            2 LIMIT  read/write
//            3 STATUS [0] match, write 1 to clear
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module wb_counter_bank #(
   parameter int NCH   = 4,
   parameter int WIDTH = 32,
   parameter int CHB   = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   // Wishbone slave
   input  logic                   wbs_cyc_i,
   input  logic                   wbs_stb_i,
   input  logic                   wbs_we_i,
   input  logic [3:0]             wbs_sel_i,
   input  logic [31:0]            wbs_adr_i,
   input  logic [31:0]            wbs_dat_i,
   output logic                   wbs_ack_o,
   output logic [31:0]            wbs_dat_o,
   // Logic-analyzer load path
   input  logic                   la_load,
   input  logic [CHB-1:0]         la_sel,
   input  logic [WIDTH-1:0]       la_value,
   // Exported state
   output logic [NCH*WIDTH-1:0]   count_bus,
   output logic [NCH-1:0]         irq
);

   localparam logic [1:0]       c_REG_CTRL   = 2'd0;
   localparam logic [1:0]       c_REG_COUNT  = 2'd1;
   localparam logic [1:0]       c_REG_LIMIT  = 2'd2;
   localparam logic [1:0]       c_REG_STATUS = 2'd3;
   localparam logic [WIDTH-1:0] c_ONE        = WIDTH'(1);

   // Byte-lane merge of write data into an existing register image.
   function automatic logic [31:0] f_merge(
      input logic [31:0] old_val,
      input logic [31:0] wr_val,
      input logic [3:0]  sel
   );
      logic [31:0] res;
      res = old_val;
      for (int b = 0; b < 4; b++) begin
         if (sel[b]) begin
            res[b*8 +: 8] = wr_val[b*8 +: 8];
         end
      end
      return res;
   endfunction

   // ------------------------------------------------------------------------
   // Wishbone decode
   // ------------------------------------------------------------------------
   logic           w_valid;
   logic           w_acc;      // the cycle whose edge raises ack
   logic           w_wr;
   logic [CHB-1:0] w_ch;
   logic [1:0]     w_reg;
   logic [31:0]    w_rdata;

   assign w_valid = wbs_cyc_i & wbs_stb_i;
   // A new access is taken only while ack is low, which also guarantees
   // ack drops for at least one cycle between back-to-back accesses.
   assign w_acc   = w_valid & ~wbs_ack_o;
   assign w_wr    = w_acc & wbs_we_i;
   assign w_ch    = wbs_adr_i[4 +: CHB];
   assign w_reg   = wbs_adr_i[3:2];

   // Address bits that take no part in decoding.
   logic w_unused;
   assign w_unused = &{1'b0, wbs_adr_i[31:4+CHB], wbs_adr_i[1:0]};

   // Per-channel state gathered into flat buses for the read mux.
   logic [NCH*WIDTH-1:0] w_cnt_bus;
   logic [NCH*WIDTH-1:0] w_lim_bus;
   logic [NCH*4-1:0]     w_ctrl_bus;
   logic [NCH-1:0]       w_match_bus;

   assign count_bus = w_cnt_bus;

   // ------------------------------------------------------------------------
   // Counter channels
   // ------------------------------------------------------------------------
   for (genvar gi = 0; gi < NCH; gi++) begin : g_ch
      logic [WIDTH-1:0] r_count;
      logic [WIDTH-1:0] r_limit;
      logic             r_en;
      logic             r_dir;
      logic             r_oneshot;
      logic             r_irq_en;
      logic             r_match;

      logic             w_sel_ch;
      logic             w_wr_ctrl;
      logic             w_wr_count;
      logic             w_wr_limit;
      logic             w_wr_status;
      logic             w_la_hit;
      logic             w_step;
      logic             w_term;
      logic             w_set_match;
      logic [3:0]       w_ctrl_new;
      logic [WIDTH-1:0] w_count_wr;
      logic [WIDTH-1:0] w_limit_wr;
      logic [WIDTH-1:0] w_count_step;

      // Channel indices >= NCH never match any gi, so such accesses are
      // silently ignored on write and read back as zero.
      assign w_sel_ch    = (w_ch == CHB'(gi));
      assign w_wr_ctrl   = w_wr & w_sel_ch & (w_reg == c_REG_CTRL);
      assign w_wr_count  = w_wr & w_sel_ch & (w_reg == c_REG_COUNT);
      assign w_wr_limit  = w_wr & w_sel_ch & (w_reg == c_REG_LIMIT);
      assign w_wr_status = w_wr & w_sel_ch & (w_reg == c_REG_STATUS);
      assign w_la_hit    = la_load & (la_sel == CHB'(gi));

      // Any explicit load of the count suppresses the counting step.
      assign w_step      = r_en & ~w_wr_count & ~w_la_hit;
      assign w_term      = r_dir ? (r_count == '0) : (r_count == r_limit);
      assign w_set_match = w_step & w_term;

      // Partial writes merge with the pre-step count / current register.
      assign w_ctrl_new  = 4'(f_merge({28'd0, r_irq_en, r_oneshot, r_dir, r_en},
                                      wbs_dat_i, wbs_sel_i));
      assign w_count_wr  = WIDTH'(f_merge(32'(r_count), wbs_dat_i, wbs_sel_i));
      assign w_limit_wr  = WIDTH'(f_merge(32'(r_limit), wbs_dat_i, wbs_sel_i));

      always_comb begin
         w_count_step = r_count;
         if (w_term) begin
            if (r_oneshot) begin
               w_count_step = r_count;
            end else if (r_dir) begin
               w_count_step = r_limit;
            end else begin
               w_count_step = '0;
            end
         end else if (r_dir) begin
            w_count_step = r_count - c_ONE;
         end else begin
            w_count_step = r_count + c_ONE;
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            r_count   <= '0;
            r_limit   <= '1;
            r_en      <= 1'b0;
            r_dir     <= 1'b0;
            r_oneshot <= 1'b0;
            r_irq_en  <= 1'b0;
            r_match   <= 1'b0;
         end else begin
            // Count source priority: bus write, then LA load, then step.
            if (w_wr_count) begin
               r_count <= w_count_wr;
            end else if (w_la_hit) begin
               r_count <= la_value;
            end else if (w_step) begin
               r_count <= w_count_step;
            end

            if (w_wr_limit) begin
               r_limit <= w_limit_wr;
            end

            // A software CTRL write overrides the one-shot self-disable.
            if (w_wr_ctrl) begin
               {r_irq_en, r_oneshot, r_dir, r_en} <= w_ctrl_new;
            end else if (w_set_match && r_oneshot) begin
               r_en <= 1'b0;
            end

            // Hardware set beats a simultaneous write-1-to-clear.
            if (w_set_match) begin
               r_match <= 1'b1;
            end else if (w_wr_status && wbs_sel_i[0] && wbs_dat_i[0]) begin
               r_match <= 1'b0;
            end
         end
      end

      assign w_cnt_bus[gi*WIDTH +: WIDTH] = r_count;
      assign w_lim_bus[gi*WIDTH +: WIDTH] = r_limit;
      assign w_ctrl_bus[gi*4 +: 4]        = {r_irq_en, r_oneshot, r_dir, r_en};
      assign w_match_bus[gi]              = r_match;
      assign irq[gi]                      = r_match & r_irq_en;
   end

   // ------------------------------------------------------------------------
   // Read mux (unmapped channels read zero)
   // ------------------------------------------------------------------------
   always_comb begin
      w_rdata = '0;
      for (int i = 0; i < NCH; i++) begin
         if (w_ch == CHB'(i)) begin
            case (w_reg)
               c_REG_CTRL:   w_rdata = 32'(w_ctrl_bus[i*4 +: 4]);
               c_REG_COUNT:  w_rdata = 32'(w_cnt_bus[i*WIDTH +: WIDTH]);
               c_REG_LIMIT:  w_rdata = 32'(w_lim_bus[i*WIDTH +: WIDTH]);
               default:      w_rdata = 32'(w_match_bus[i]);
            endcase
         end
      end
   end

   // ------------------------------------------------------------------------
   // Acknowledge and registered read data
   // ------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         wbs_ack_o <= 1'b0;
         wbs_dat_o <= '0;
      end else begin
         wbs_ack_o <= w_acc;
         if (w_acc && !wbs_we_i) begin
            wbs_dat_o <= w_rdata;
         end
      end
   end

endmodule
`default_nettype wire

// File: doc/wb_counter_bank.md
Name: wb_counter_bank

Overview:
- Parameterised bank of NCH independent up/down counter-timers, each with its own limit, mode and sticky match flag.
- Controlled from the management SoC over the Wishbone slave port. Bulk-loadable from logic-analyzer probes.
- Drives per-channel IRQs and exports every count value for the IO pads and LA readback.
- Successor to the single free-running counter. Adds channels, down-counting, one-shot mode, compare/reload and interrupts.

Parameters:
- NCH, 4, number of counter channels (1..16)
- WIDTH, 32, counter width in bits (1..32)
- CHB, 2, channel-index bits, must be ≥ clog2(NCH)

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- wbs_cyc_i  in  1  Wishbone cycle
- wbs_stb_i  in  1  Wishbone strobe
- wbs_we_i  in  1  write enable
- wbs_sel_i  in  4  byte strobes
- wbs_adr_i  in  32  byte address; [3:2] selects the register, [4+:CHB] selects the channel
- wbs_dat_i  in  32  write data
- wbs_ack_o  out  1  acknowledge
- wbs_dat_o  out  32  read data
- la_load  in  1  LA load strobe
- la_sel  in  CHB  LA target channel
- la_value  in  WIDTH  LA load value
- count_bus  out  NCH*WIDTH  all counts; channel i at [i*WIDTH+:WIDTH]
- irq  out  NCH  per-channel interrupt, equal to match & irq_en

Behaviour:
- Clock and reset: reset is synchronous, active-high; clock is clk.
- Values after reset:
  - all counts 0; all limits all-ones
  - CTRL 0 for every channel
  - match 0; irq 0; wbs_ack_o 0; wbs_dat_o 0
- Register map per channel (reg = adr[3:2]):
  - 0 CTRL: [0] en, [1] dir (0 up, 1 down), [2] oneshot, [3] irq_en; other bits read 0
  - 1 COUNT: read/write
  - 2 LIMIT: read/write
  - 3 STATUS: [0] match; write 1 to clear
  - Writes honour wbs_sel_i byte-wise. Bits at or above WIDTH are ignored on write and read as 0.
- Wishbone handshake:
  - valid = cyc & stb.
  - ack is asserted for exactly one cycle, in the cycle after valid is first seen while ack is low.
  - ack deasserts for at least one cycle before the next ack.
  - Write side effects happen on the acked edge. wbs_dat_o is registered with ack.
  - An address to a channel ≥ NCH still acks. It reads 0 and writes have no effect.
- Counting, per channel, each cycle with en=1:
  - Up, count==limit: set match. Periodic mode: count←0. One-shot mode: count holds and en←0.
  - Up, otherwise: count←count+1.
  - Down, count==0: set match. Periodic mode: count←limit. One-shot mode: count holds and en←0.
  - Down, otherwise: count←count−1.
  - All arithmetic is modulo 2^WIDTH. limit=0 in up mode matches every cycle.
- Priority on a channel's count within one cycle: WB COUNT write > la_load > counting step.
  - The step is suppressed for that cycle.
  - A partial-byte WB write merges with the current (pre-step) count.
- la_load with la_sel ≥ NCH has no effect.
- match hardware set and a W1C in the same cycle: set wins, match stays 1.
- A CTRL write that sets en on a one-shot channel already sitting at its terminal value:
  - fires match on the next enabled cycle.
  - then stops again.
- Disabling (en←0) freezes count. match is unaffected.
- irq is combinational from the registered match and irq_en.
- Reset mid-transaction:
  - ack is forced low and any pending write is dropped.
  - the master must restart the cycle.

Test Plan:
- Reset, then read CTRL/COUNT/LIMIT/STATUS of ch0 -> 0, 0, 0xFFFFFFFF, 0; irq=0; ack exactly 1 cycle after stb.
- ch1 LIMIT=3, CTRL=0b1001 (up, periodic, irq_en) -> count 0,1,2,3,0,1…; match and irq[1] set on the 3→0 edge. W1C STATUS clears irq[1] until the next wrap.
- ch2 COUNT=5, CTRL=0b0111 (down, one-shot) -> 5,4,3,2,1,0, then holds at 0; match=1; CTRL reads 0b0110.
- Write COUNT=0x1234 with sel=0b0001 on ch0 holding 0xAABBCCDD -> 0xAABBCC34. The counting step is skipped in the write cycle.
- la_load=1, la_sel=3, la_value=0x100 in the same cycle as a WB COUNT write of 0x7 to ch3 -> ch3 count=0x7. A la_load alone in the next cycle -> 0x100.
- Match-set and STATUS W1C in the same cycle on ch1 -> match remains 1. Reset asserted during a pending WB write -> no ack, register unchanged (reset values).
